// File: rtl/motion_pkg.sv
// ---------------------------------------------------------------------------
// motion_pkg
// Purpose : shared state encoding, direction type and one-hot Motion codes
//           for the formation controller, the single-alien mover and the
//           projectile blocks.
// Contents: state_t, dir_t, MOT_* codes, motion_of(), pick_dir().
// ---------------------------------------------------------------------------
package motion_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RIGHT  = 3'd1,
      ST_LEFT   = 3'd2,
      ST_DOWN   = 3'd3,
      ST_LANDED = 3'd4
   } state_t;

   typedef enum logic {
      DIR_RIGHT = 1'b0,
      DIR_LEFT  = 1'b1
   } dir_t;

   localparam logic [2:0] MOT_NONE  = 3'b000;
   localparam logic [2:0] MOT_RIGHT = 3'b100;
   localparam logic [2:0] MOT_DOWN  = 3'b010;
   localparam logic [2:0] MOT_LEFT  = 3'b001;

   // Motion code presented while sitting in a given state.
   function automatic logic [2:0] motion_of(state_t s);
      case (s)
         ST_RIGHT: return MOT_RIGHT;
         ST_LEFT:  return MOT_LEFT;
         ST_DOWN:  return MOT_DOWN;
         default:  return MOT_NONE;
      endcase
   endfunction

   // Try the first-choice direction, then the other one, else stay idle.
   function automatic state_t pick_dir(dir_t first, logic can_left, logic can_right);
      if (first == DIR_LEFT)
         return can_left ? ST_LEFT : (can_right ? ST_RIGHT : ST_IDLE);
      else
         return can_right ? ST_RIGHT : (can_left ? ST_LEFT : ST_IDLE);
   endfunction

endpackage

// File: rtl/zigzag_formation_ctrl_if.sv
// ---------------------------------------------------------------------------
// zigzag_formation_ctrl_if
// Purpose : bundles the game-tick/permission inputs and the motion outputs
//           of the formation controller.
// Signals : enable, canLeft, canRight, canDown      (towards controller)
//           Motion[2:0], step, landed, rowCount, period (from controller)
// Modports: master = controller side, slave = tick source / position regs.
// ---------------------------------------------------------------------------
interface zigzag_formation_ctrl_if #(
   parameter int PER_W = 8,
   parameter int ROW_W = 5
) ();
   logic             enable;
   logic             canLeft;
   logic             canRight;
   logic             canDown;
   logic [2:0]       Motion;
   logic             step;
   logic             landed;
   logic [ROW_W-1:0] rowCount;
   logic [PER_W-1:0] period;

   modport master (
      input  enable, canLeft, canRight, canDown,
      output Motion, step, landed, rowCount, period
   );

   modport slave (
      output enable, canLeft, canRight, canDown,
      input  Motion, step, landed, rowCount, period
   );
endinterface

// File: rtl/zigzag_formation_ctrl_step_prescaler.sv
// ---------------------------------------------------------------------------
// step_prescaler
// Purpose : game-tick down-counter. Counts enabled edges and flags the edge
//           on which the counter sits at zero (a "step edge"); on that edge
//           it reloads with i_reload, otherwise it decrements.
// Ports   : clk, reset (sync, active-low), i_enable, i_reload[CNT_W-1:0],
//           o_step_edge (combinational, valid for the current edge)
// ---------------------------------------------------------------------------
module step_prescaler #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_enable,
   input  logic [CNT_W-1:0] i_reload,
   output logic             o_step_edge
);

   logic [CNT_W-1:0] r_cnt;

   // Reset has priority, so no step edge is reported while reset is low.
   assign o_step_edge = reset && i_enable && (r_cnt == '0);

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (i_enable) begin
         r_cnt <= (r_cnt == '0) ? i_reload : r_cnt - 1'b1;
      end
   end

endmodule

// File: rtl/zigzag_formation_ctrl.sv
// ---------------------------------------------------------------------------
// zigzag_formation_ctrl
// Purpose : drives the alien formation right/left, descends DOWN_STEPS rows
//           at each wall, speeds up every SPEEDUP_ROWS completed rows and
//           latches landing when blocked while descending.
// Ports   : clk, reset (sync, active-low, 0 = reset)
//           bus (master): enable, canLeft, canRight, canDown in;
//                         Motion, step, landed, rowCount, period out
// ---------------------------------------------------------------------------
module zigzag_formation_ctrl
   import motion_pkg::*;
#(
   parameter int DOWN_STEPS   = 2,
   parameter int PERIOD_INIT  = 8,
   parameter int PERIOD_MIN   = 2,
   parameter int SPEEDUP_ROWS = 1,
   parameter int PER_W        = 8,
   parameter int ROW_W        = 5,
   parameter int START_LEFT   = 0
) (
   input logic                     clk,
   input logic                     reset,
   zigzag_formation_ctrl_if.master bus
);

   localparam int   DC_W      = (DOWN_STEPS > 1) ? $clog2(DOWN_STEPS) : 1;
   localparam int   SP_W      = (SPEEDUP_ROWS > 1) ? $clog2(SPEEDUP_ROWS) : 1;
   localparam dir_t START_DIR = (START_LEFT != 0) ? DIR_LEFT : DIR_RIGHT;

   if (DOWN_STEPS < 1 || PERIOD_MIN < 1 || PERIOD_INIT < PERIOD_MIN ||
       SPEEDUP_ROWS < 1 || PER_W < 1 || ROW_W < 1 ||
       longint'(PERIOD_INIT) >= (longint'(1) << PER_W)) begin : g_param_check
      $error("zigzag_formation_ctrl: illegal parameter combination");
   end

   state_t           r_state;
   dir_t             r_last_dir;
   logic [DC_W-1:0]  r_down_cnt;
   logic [SP_W-1:0]  r_speed_cnt;
   logic [PER_W-1:0] r_period;
   logic [ROW_W-1:0] r_row_count;
   logic [2:0]       r_motion;
   logic             r_step;
   logic             r_landed;

   logic             w_step_edge;
   logic             w_row_done;
   logic             w_speedup;
   logic [PER_W-1:0] w_period_next;
   logic [PER_W-1:0] w_reload;
   state_t           w_state_next;
   dir_t             w_dir_next;
   logic [DC_W-1:0]  w_down_next;

   // Only meaningful on a step edge; the FSM and prescaler gate on that.
   assign w_row_done = (r_state == ST_DOWN) && (r_down_cnt == '0);
   assign w_speedup  = w_row_done && (r_speed_cnt == SP_W'(SPEEDUP_ROWS - 1));

   assign w_period_next = !w_speedup ? r_period :
                          (r_period > PER_W'(PERIOD_MIN)) ? r_period - 1'b1 :
                          PER_W'(PERIOD_MIN);

   // The reload on a row-complete edge already uses the sped-up period.
   assign w_reload = w_period_next - 1'b1;

   step_prescaler #(
      .CNT_W (PER_W)
   ) u_prescaler (
      .clk         (clk),
      .reset       (reset),
      .i_enable    (bus.enable),
      .i_reload    (w_reload),
      .o_step_edge (w_step_edge)
   );

   always_comb begin
      w_state_next = r_state;
      w_dir_next   = r_last_dir;
      w_down_next  = r_down_cnt;
      case (r_state)
         ST_IDLE: begin
            w_state_next = pick_dir(START_DIR, bus.canLeft, bus.canRight);
         end
         ST_RIGHT, ST_LEFT: begin
            if ((r_state == ST_RIGHT) ? bus.canRight : bus.canLeft) begin
               w_state_next = r_state;
            end else if (bus.canDown) begin
               w_state_next = ST_DOWN;
               w_dir_next   = (r_state == ST_RIGHT) ? DIR_RIGHT : DIR_LEFT;
               w_down_next  = DC_W'(DOWN_STEPS - 1);
            end else begin
               w_state_next = ST_LANDED;
            end
         end
         ST_DOWN: begin
            if (r_down_cnt != '0) begin
               if (bus.canDown) begin
                  w_down_next = r_down_cnt - 1'b1;
               end else begin
                  w_state_next = ST_LANDED;
               end
            end else begin
               // Row complete: reverse if possible, else keep going, else wait.
               w_state_next = pick_dir((r_last_dir == DIR_RIGHT) ? DIR_LEFT : DIR_RIGHT,
                                       bus.canLeft, bus.canRight);
            end
         end
         default: begin
            w_state_next = ST_LANDED;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_last_dir  <= DIR_RIGHT;
         r_down_cnt  <= '0;
         r_speed_cnt <= '0;
         r_period    <= PER_W'(PERIOD_INIT);
         r_row_count <= '0;
         r_motion    <= MOT_NONE;
         r_step      <= 1'b0;
         r_landed    <= 1'b0;
      end else begin
         r_step <= 1'b0;
         if (w_step_edge) begin
            r_state    <= w_state_next;
            r_last_dir <= w_dir_next;
            r_down_cnt <= w_down_next;
            r_period   <= w_period_next;
            r_motion   <= motion_of(w_state_next);
            r_step     <= (w_state_next == ST_RIGHT) || (w_state_next == ST_LEFT) ||
                          (w_state_next == ST_DOWN);
            r_landed   <= r_landed || (w_state_next == ST_LANDED);
            if (w_row_done) begin
               if (r_row_count != '1) begin
                  r_row_count <= r_row_count + 1'b1;
               end
               r_speed_cnt <= w_speedup ? '0 : r_speed_cnt + 1'b1;
            end
         end
      end
   end

   assign bus.Motion   = r_motion;
   assign bus.step     = r_step;
   assign bus.landed   = r_landed;
   assign bus.rowCount = r_row_count;
   assign bus.period   = r_period;

endmodule

// File: tb/tb_zigzag_formation_ctrl.sv
// ---------------------------------------------------------------------------
// tb_zigzag_formation_ctrl
// Purpose : directed, self-checking bench. Expected step records (Motion,
//           rowCount, period, cycles since previous step) are queued as the
//           stimulus is set up and checked whenever the DUT pulses step.
// ---------------------------------------------------------------------------
module tb_zigzag_formation_ctrl;
   import motion_pkg::*;

   localparam int PINIT = 4;
   localparam int PMIN  = 2;
   localparam int RMAX  = 31;

   typedef struct {
      logic [2:0] mot;
      int         row;
      int         per;
      int         gap;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   last_step = 0;
   exp_t q[$];

   always #5 clk = ~clk;

   zigzag_formation_ctrl_if #(.PER_W(8), .ROW_W(5)) bus ();

   zigzag_formation_ctrl #(
      .DOWN_STEPS   (2),
      .PERIOD_INIT  (PINIT),
      .PERIOD_MIN   (PMIN),
      .SPEEDUP_ROWS (1),
      .PER_W        (8),
      .ROW_W        (5),
      .START_LEFT   (0)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [2:0] m, input int row, input int per, input int gap);
      exp_t e;
      e.mot = m;
      e.row = row;
      e.per = per;
      e.gap = gap;
      q.push_back(e);
   endtask

   // Wait (bounded) until every queued step has been observed.
   task automatic drain(input int bound);
      int n;
      n = 0;
      while (q.size() != 0 && n < bound) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("drain", q.size(), 0);
      if (q.size() != 0) q.delete();
   endtask

   task automatic cycles(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_motion"}, bus.Motion, MOT_NONE);
      chk({tag, "_step"},   bus.step, 0);
      chk({tag, "_landed"}, bus.landed, 0);
      chk({tag, "_row"},    bus.rowCount, 0);
      chk({tag, "_period"}, bus.period, PINIT);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Step monitor: one line per observed step.
   always @(negedge clk) begin
      if (!reset) begin
         last_step <= cyc;
      end else if (bus.step) begin
         if (q.size() == 0) begin
            chk("unexpected_step", bus.step, 0);
         end else begin
            $display("step @%0d motion=%b row=%0d period=%0d gap=%0d",
                     cyc, bus.Motion, bus.rowCount, bus.period, cyc - last_step);
            chk("step_motion", bus.Motion, q[0].mot);
            chk("step_row",    bus.rowCount, q[0].row);
            chk("step_period", bus.period, q[0].per);
            chk("step_gap",    cyc - last_step, q[0].gap);
            void'(q.pop_front());
         end
         last_step <= cyc;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] cur;
      logic [2:0] nd;
      int per;
      int row;
      int np;
      int nr;

      bus.enable   = 1'b1;
      bus.canRight = 1'b1;
      bus.canLeft  = 1'b0;
      bus.canDown  = 1'b0;
      reset        = 1'b0;

      // Reset held with enable and canRight high.
      repeat (3) begin
         @(negedge clk);
         chk_reset_vals("reset_hold");
         #1;
      end

      // Cadence: first step right after the first enabled edge, then every 4.
      push(MOT_RIGHT, 0, 4, 1);
      push(MOT_RIGHT, 0, 4, 4);
      push(MOT_RIGHT, 0, 4, 4);
      reset = 1'b1;
      drain(40);

      // Enable on every other cycle: step every 8 cycles.
      push(MOT_RIGHT, 0, 4, 8);
      push(MOT_RIGHT, 0, 4, 8);
      for (int k = 0; k < 16; k++) begin
         bus.enable = (k % 2 == 1);
         @(negedge clk);
         #1;
      end
      bus.enable = 1'b1;
      drain(4);

      // 40 wall hits: two down steps then reversal; speed floor and saturation.
      cur = MOT_RIGHT;
      per = PINIT;
      row = 0;
      for (int r = 0; r < 40; r++) begin
         np = (per > PMIN) ? per - 1 : PMIN;
         nr = (row == RMAX) ? RMAX : row + 1;
         nd = (cur == MOT_RIGHT) ? MOT_LEFT : MOT_RIGHT;
         bus.canDown  = 1'b1;
         bus.canRight = (cur == MOT_LEFT);
         bus.canLeft  = (cur == MOT_RIGHT);
         push(MOT_DOWN, row, per, per);
         push(MOT_DOWN, row, per, per);
         push(nd, nr, np, per);
         drain(40);
         cur = nd;
         per = np;
         row = nr;
      end

      // Landing: blocked below while one more down step is owed.
      bus.canRight = 1'b0;
      bus.canLeft  = 1'b1;
      bus.canDown  = 1'b1;
      push(MOT_DOWN, RMAX, 2, 2);
      drain(20);
      bus.canDown = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("land_landed", bus.landed, 1);
      chk("land_motion", bus.Motion, MOT_NONE);
      chk("land_step",   bus.step, 0);
      #1;
      bus.canDown  = 1'b1;
      bus.canRight = 1'b1;
      cycles(50);
      chk("land_sticky", bus.landed, 1);
      chk("land_row",    bus.rowCount, RMAX);
      reset = 1'b0;
      @(negedge clk);
      chk_reset_vals("land_reset");
      #1;

      // Dead end: row completes with both sides blocked -> idle, no step.
      bus.canRight = 1'b1;
      bus.canLeft  = 1'b0;
      bus.canDown  = 1'b1;
      push(MOT_RIGHT, 0, 4, 1);
      reset = 1'b1;
      drain(20);
      bus.canRight = 1'b0;
      push(MOT_DOWN, 0, 4, 4);
      push(MOT_DOWN, 0, 4, 4);
      drain(30);
      repeat (4) @(negedge clk);
      chk("idle_motion", bus.Motion, MOT_NONE);
      chk("idle_row",    bus.rowCount, 1);
      chk("idle_period", bus.period, 3);
      #1;
      bus.canLeft = 1'b1;
      push(MOT_LEFT, 1, 3, 7);
      drain(20);

      // Reset in the middle of moving left.
      reset = 1'b0;
      @(negedge clk);
      chk_reset_vals("midop_reset");
      #1;
      reset      = 1'b1;
      bus.enable = 1'b0;
      cycles(3);
      chk("queue_empty", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
